// File: rtl/sensor_sequencer_pkg.sv
// rtl/sensor_sequencer_pkg.sv - state encoding and default constants for the sensor sequencer
package sensor_sequencer_pkg;

   typedef enum logic [3:0] {
      INIT     = 4'd0,
      CFG_REQ  = 4'd1,
      CFG_WAIT = 4'd2,
      IDLE     = 4'd3,
      PTR_REQ  = 4'd4,
      PTR_WAIT = 4'd5,
      RDH_REQ  = 4'd6,
      RDH_WAIT = 4'd7,
      RDL_REQ  = 4'd8,
      RDL_WAIT = 4'd9,
      DONE     = 4'd10
   } state_t;

   localparam logic [6:0]  DEF_SENS_ADDR = 7'h48;
   localparam logic [7:0]  DEF_CFG_REG   = 8'h01;
   localparam logic [7:0]  DEF_CFG_VAL   = 8'h60;
   localparam logic [7:0]  DEF_DATA_REG  = 8'h00;
   localparam int unsigned DEF_PERIOD    = 100000;
   localparam int unsigned DEF_TIMEOUT   = 4096;

   function automatic logic in_phase(input state_t s);
      return (s inside {CFG_REQ, CFG_WAIT, PTR_REQ, PTR_WAIT,
                        RDH_REQ, RDH_WAIT, RDL_REQ, RDL_WAIT});
   endfunction

   function automatic logic is_cfg(input state_t s);
      return (s inside {CFG_REQ, CFG_WAIT});
   endfunction

   function automatic state_t wait_of(input state_t s);
      case (s)
         CFG_REQ: return CFG_WAIT;
         PTR_REQ: return PTR_WAIT;
         RDH_REQ: return RDH_WAIT;
         RDL_REQ: return RDL_WAIT;
         default: return INIT;
      endcase
   endfunction

endpackage

// File: rtl/sensor_sequencer_sync_2ff.sv
// rtl/sensor_sequencer_sync_2ff.sv - two-flop synchronizer for the controller ready flag
module sync_2ff (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_d,
   output logic o_q
);

   logic r_meta;
   logic r_sync;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_meta <= 1'b0;
         r_sync <= 1'b0;
      end else begin
         r_meta <= i_d;
         r_sync <= r_meta;
      end
   end

   assign o_q = r_sync;

endmodule

// File: rtl/sensor_sequencer.sv
// rtl/sensor_sequencer.sv - configures an I2C sensor once, then reads 16-bit samples on request or period
module sensor_sequencer
   import sensor_sequencer_pkg::*;
#(
   parameter logic [6:0]  SENS_ADDR = DEF_SENS_ADDR,
   parameter logic [7:0]  CFG_REG   = DEF_CFG_REG,
   parameter logic [7:0]  CFG_VAL   = DEF_CFG_VAL,
   parameter logic [7:0]  DATA_REG  = DEF_DATA_REG,
   parameter int unsigned PERIOD    = DEF_PERIOD,
   parameter int unsigned TIMEOUT   = DEF_TIMEOUT
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic        ready,
   input  logic [7:0]  data_out,
   output logic [6:0]  addr,
   output logic [7:0]  data_in,
   output logic [7:0]  data_in_2,
   output logic        ena_w_data_2,
   output logic        enable,
   output logic        rw,
   output logic [15:0] sample,
   output logic        sample_valid,
   output logic        busy,
   output logic        err
);

   state_t      r_state;
   state_t      w_next;
   logic        r_enable;
   logic        w_enable_nxt;
   logic        w_load;
   logic        w_timeout;
   logic        w_ready_s;
   logic [31:0] r_tmo;
   logic [31:0] r_per;
   logic [7:0]  r_msb;
   logic [7:0]  r_lsb;
   logic [7:0]  r_data_in;
   logic [7:0]  r_data_in_2;
   logic        r_rw;
   logic        r_ena2;
   logic        r_valid;
   logic        r_err;
   logic [15:0] r_sample;

   sync_2ff u_sync (
      .i_clk   (clk),
      .i_rst_n (rst),
      .i_d     (ready),
      .o_q     (w_ready_s)
   );

   always_comb begin
      w_next       = r_state;
      w_enable_nxt = r_enable;
      w_load       = 1'b0;
      w_timeout    = 1'b0;
      case (r_state)
         INIT: w_next = CFG_REQ;
         CFG_REQ, PTR_REQ, RDH_REQ, RDL_REQ: begin
            // Raise enable once the controller is idle; the controller taking it shows as ready falling.
            if (!r_enable) begin
               if (w_ready_s) begin
                  w_enable_nxt = 1'b1;
                  w_load       = 1'b1;
               end
            end else if (!w_ready_s) begin
               w_enable_nxt = 1'b0;
               w_next       = wait_of(r_state);
            end
         end
         CFG_WAIT: if (w_ready_s) w_next = IDLE;
         PTR_WAIT: if (w_ready_s) w_next = RDH_REQ;
         RDH_WAIT: if (w_ready_s) w_next = RDL_REQ;
         RDL_WAIT: if (w_ready_s) w_next = DONE;
         IDLE: begin
            if (start || ((PERIOD != 0) && (r_per == PERIOD - 1))) w_next = PTR_REQ;
         end
         DONE:    w_next = IDLE;
         default: w_next = INIT;
      endcase
      if (in_phase(r_state) && (r_tmo == TIMEOUT - 1) && (w_next == r_state)) begin
         w_timeout    = 1'b1;
         w_enable_nxt = 1'b0;
         w_load       = 1'b0;
         w_next       = is_cfg(r_state) ? INIT : IDLE;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state     <= INIT;
         r_enable    <= 1'b0;
         r_tmo       <= '0;
         r_per       <= '0;
         r_msb       <= '0;
         r_lsb       <= '0;
         r_data_in   <= '0;
         r_data_in_2 <= '0;
         r_rw        <= 1'b0;
         r_ena2      <= 1'b0;
         r_valid     <= 1'b0;
         r_err       <= 1'b0;
         r_sample    <= '0;
      end else begin
         r_state  <= w_next;
         r_enable <= w_enable_nxt;
         r_valid  <= (r_state == DONE);

         if ((w_next != r_state) || !in_phase(r_state)) r_tmo <= '0;
         else                                            r_tmo <= r_tmo + 32'd1;

         if ((r_state == IDLE) && (w_next == IDLE)) r_per <= r_per + 32'd1;
         else                                        r_per <= '0;

         if (w_load) begin
            case (r_state)
               CFG_REQ: begin
                  r_rw        <= 1'b0;
                  r_data_in   <= CFG_REG;
                  r_data_in_2 <= CFG_VAL;
                  r_ena2      <= 1'b1;
               end
               PTR_REQ: begin
                  r_rw      <= 1'b0;
                  r_data_in <= DATA_REG;
                  r_ena2    <= 1'b0;
               end
               default: begin
                  r_rw   <= 1'b1;
                  r_ena2 <= 1'b0;
               end
            endcase
         end

         if ((r_state == RDH_WAIT) && (w_next == RDL_REQ)) r_msb <= data_out;
         if ((r_state == RDL_WAIT) && (w_next == DONE))    r_lsb <= data_out;

         if (r_state == DONE) begin
            r_sample <= {r_msb, r_lsb};
            r_err    <= 1'b0;
         end else if (w_timeout) begin
            r_err <= 1'b1;
         end
      end
   end

   assign addr         = SENS_ADDR;
   assign data_in      = r_data_in;
   assign data_in_2    = r_data_in_2;
   assign ena_w_data_2 = r_ena2;
   assign enable       = r_enable;
   assign rw           = r_rw;
   assign sample       = r_sample;
   assign sample_valid = r_valid;
   assign busy         = (r_state != IDLE);
   assign err          = r_err;

endmodule

// File: tb/tb_sensor_sequencer.sv
// tb/tb_sensor_sequencer.sv - self-checking bench for sensor_sequencer with an I2C controller model
module tb_sensor_sequencer;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic        ready;
   logic [7:0]  data_out;
   logic [6:0]  addr;
   logic [7:0]  data_in;
   logic [7:0]  data_in_2;
   logic        ena_w_data_2;
   logic        enable;
   logic        rw;
   logic [15:0] sample;
   logic        sample_valid;
   logic        busy;
   logic        err;

   int checks   = 0;
   int failures = 0;

   // controller model and sequence-grammar model state
   int          pos      = 0;
   int          lat_pos  = 0;
   int          ctl_cnt  = 0;
   int          rd_ptr   = 0;
   int          n_cfg    = 0;
   int          n_rdl    = 0;
   int          n_valid  = 0;
   logic        hang_reads;
   logic [7:0]  hi;
   logic [15:0] exp_sample_q[$];
   logic [15:0] last_sample = 16'h0000;
   logic [15:0] exp_s;
   logic [7:0]  rd_bytes [16] = '{8'h1A, 8'h2B, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88,
                                  8'h99, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE, 8'h11, 8'h22};

   sensor_sequencer #(.PERIOD(50), .TIMEOUT(64)) dut (
      .clk          (clk),
      .rst          (rst),
      .start        (start),
      .ready        (ready),
      .data_out     (data_out),
      .addr         (addr),
      .data_in      (data_in),
      .data_in_2    (data_in_2),
      .ena_w_data_2 (ena_w_data_2),
      .enable       (enable),
      .rw           (rw),
      .sample       (sample),
      .sample_valid (sample_valid),
      .busy         (busy),
      .err          (err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
      end
   endtask

   // Controller: accepts a transaction when idle, stays busy 6 cycles, serves reads from rd_bytes.
   // Expected fields follow the sequence grammar CFG, then (PTR, RDH, RDL) repeated.
   always @(negedge clk) begin
      if (!rst) begin
         ready   = 1'b1;
         ctl_cnt = 0;
         pos     = 0;
      end else if (ready && enable) begin
         if (hang_reads && rw) begin
            pos = 1;
         end else begin
            chk("txn_addr", 32'(addr), 32'h48);
            case (pos)
               0: begin
                  chk("cfg_rw", 32'(rw), 32'd0);
                  chk("cfg_data_in", 32'(data_in), 32'h01);
                  chk("cfg_data_in_2", 32'(data_in_2), 32'h60);
                  chk("cfg_ena2", 32'(ena_w_data_2), 32'd1);
               end
               1: begin
                  chk("ptr_rw", 32'(rw), 32'd0);
                  chk("ptr_data_in", 32'(data_in), 32'h00);
                  chk("ptr_ena2", 32'(ena_w_data_2), 32'd0);
               end
               default: begin
                  chk("rd_rw", 32'(rw), 32'd1);
                  chk("rd_ena2", 32'(ena_w_data_2), 32'd0);
               end
            endcase
            lat_pos = pos;
            pos     = (pos == 3) ? 1 : pos + 1;
            if (lat_pos == 0) n_cfg++;
            if (lat_pos == 3) n_rdl++;
            ready   = 1'b0;
            ctl_cnt = 6;
         end
      end else if (!ready) begin
         ctl_cnt--;
         if (ctl_cnt == 0) begin
            if (lat_pos >= 2) begin
               data_out = rd_bytes[rd_ptr];
               rd_ptr   = (rd_ptr + 1) % 16;
               if (lat_pos == 2) hi = data_out;
               else              exp_sample_q.push_back({hi, data_out});
            end
            ready = 1'b1;
         end
      end
   end

   // Per-cycle compare: each valid pulse delivers the next completed read pair; sample holds otherwise.
   always @(negedge clk) begin
      if (!rst) begin
         last_sample = 16'h0000;
         exp_sample_q.delete();
      end else begin
         if (sample_valid) begin
            n_valid++;
            if (exp_sample_q.size() == 0) begin
               chk("unexpected_valid", 32'(sample_valid), 32'd0);
            end else begin
               exp_s = exp_sample_q.pop_front();
               chk("sample_on_valid", 32'(sample), 32'(exp_s));
               last_sample = exp_s;
            end
         end else begin
            chk("sample_hold", 32'(sample), 32'(last_sample));
         end
         if (!busy) chk("enable_low_in_idle", 32'(enable), 32'd0);
      end
   end

   task automatic wait_valid(input string nm);
      int k;
      k = 0;
      @(negedge clk);
      while (!sample_valid && k < 400) begin
         @(negedge clk);
         k++;
      end
      chk(nm, 32'(sample_valid), 32'd1);
      #1;
   endtask

   task automatic idle_len(output int n);
      n = 0;
      while (!busy && n < 200) begin
         n++;
         @(negedge clk);
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog simulation did not finish");
      $fatal(1);
   end

   initial begin
      int k;
      int n;
      int nv;
      int nr;
      int nc;
      rst        = 1'b0;
      start      = 1'b0;
      hang_reads = 1'b0;
      ready      = 1'b1;
      data_out   = 8'h00;
      repeat (3) @(negedge clk);
      chk("rst_busy", 32'(busy), 32'd1);
      chk("rst_enable", 32'(enable), 32'd0);
      chk("rst_rw", 32'(rw), 32'd0);
      chk("rst_ena2", 32'(ena_w_data_2), 32'd0);
      chk("rst_addr", 32'(addr), 32'h48);
      chk("rst_data_in", 32'(data_in), 32'h00);
      chk("rst_data_in_2", 32'(data_in_2), 32'h00);
      chk("rst_sample", 32'(sample), 32'h0000);
      chk("rst_valid", 32'(sample_valid), 32'd0);
      chk("rst_err", 32'(err), 32'd0);
      rst = 1'b1;

      // configuration then auto-sampling every 50 idle cycles
      k = 0;
      while (busy && k < 300) begin
         @(negedge clk);
         k++;
      end
      chk("cfg_then_idle", 32'(busy), 32'd0);
      chk("cfg_count", 32'(n_cfg), 32'd1);
      chk("cfg_err", 32'(err), 32'd0);
      idle_len(n);
      chk("period_first_idle", 32'(n), 32'd50);
      wait_valid("auto1_valid");
      chk("auto1_sample", 32'(sample), 32'h1A2B);
      chk("auto1_err", 32'(err), 32'd0);
      idle_len(n);
      chk("period_after_done", 32'(n), 32'd50);
      wait_valid("auto2_valid");
      chk("auto2_sample", 32'(sample), 32'h3344);

      // start pulse
      nv    = n_valid;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk("start_busy", 32'(busy), 32'd1);
      wait_valid("start_valid");
      chk("start_sample", 32'(sample), 32'h5566);
      chk("start_one_pulse", 32'(n_valid - nv), 32'd1);
      chk("start_err", 32'(err), 32'd0);

      // start held through a sequence, then a fresh start in idle
      nv    = n_valid;
      start = 1'b1;
      repeat (20) @(negedge clk);
      start = 1'b0;
      wait_valid("held_valid");
      repeat (5) @(negedge clk);
      chk("held_one_seq", 32'(n_valid - nv), 32'd1);
      chk("held_sample", 32'(sample), 32'h7788);
      chk("held_idle", 32'(busy), 32'd0);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk("restart_busy", 32'(busy), 32'd1);
      wait_valid("restart_valid");
      chk("restart_two_seq", 32'(n_valid - nv), 32'd2);
      chk("restart_sample", 32'(sample), 32'h99AA);

      // controller never takes the high-byte read
      nv         = n_valid;
      hang_reads = 1'b1;
      start      = 1'b1;
      @(negedge clk);
      start = 1'b0;
      k     = 1;
      while (!err && k < 400) begin
         @(negedge clk);
         k++;
      end
      chk("timeout_err", 32'(err), 32'd1);
      chk("timeout_min_cycles", 32'(k >= 64), 32'd1);
      chk("timeout_max_cycles", 32'(k <= 104), 32'd1);
      chk("timeout_enable", 32'(enable), 32'd0);
      chk("timeout_idle", 32'(busy), 32'd0);
      chk("timeout_sample", 32'(sample), 32'h99AA);
      chk("timeout_no_valid", 32'(n_valid - nv), 32'd0);
      hang_reads = 1'b0;
      repeat (5) @(negedge clk);
      chk("err_sticky", 32'(err), 32'd1);
      wait_valid("recover_valid");
      chk("recover_err_clear", 32'(err), 32'd0);
      chk("recover_sample", 32'(sample), 32'hBBCC);

      // reset in the middle of the low-byte read
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      nr    = n_rdl;
      k     = 0;
      while (n_rdl == nr && k < 200) begin
         @(negedge clk);
         k++;
      end
      chk("rdl_reached", 32'(n_rdl - nr), 32'd1);
      repeat (3) @(negedge clk);
      rst = 1'b0;
      #1;
      chk("midrst_enable", 32'(enable), 32'd0);
      chk("midrst_busy", 32'(busy), 32'd1);
      chk("midrst_sample", 32'(sample), 32'h0000);
      chk("midrst_valid", 32'(sample_valid), 32'd0);
      nc = n_cfg;
      repeat (3) @(negedge clk);
      rst = 1'b1;
      k   = 0;
      while (n_cfg == nc && k < 100) begin
         @(negedge clk);
         k++;
      end
      chk("cfg_resent", 32'(n_cfg - nc), 32'd1);
      wait_valid("post_rst_valid");
      chk("post_rst_sample", 32'(sample), 32'hEE11);
      chk("post_rst_err", 32'(err), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
